bram_stream_reader: RTL

//   Read-side sequencer for the packet bram. On i_start it reads i_word_count

---
 rtl/bram_stream_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Read-side sequencer for the packet bram: reads a burst of consecutive words and
// streams them out over valid/ready, with a 2-entry skid FIFO hiding the read latency.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = 0;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     r_issued;
    logic                    r_pending_p1;
    logic                    r_pend_last_p1;
    logic [DATA_WIDTH-1:0]   r_mem [0:1];
    logic [1:0]              r_last_mem;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_fifo_cnt;

    logic                    w_pop;
    logic                    w_issue;
    logic                    w_last_hs;
    logic [2:0]              w_occ;

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        w_pop     = (r_fifo_cnt != 2'd0) && i_ready;
        w_occ     = {1'b0, r_fifo_cnt} + {2'b00, r_pending_p1};
        w_issue   = (r_state == S_RUN) && (r_issued < r_count) &&
                    ((w_occ - {2'b00, w_pop}) < 3'd2);
        w_last_hs = w_pop && r_last_mem[r_rd_ptr];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_word_count == CNT_ZERO) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_count        <= '0;
            r_issued       <= '0;
            r_pending_p1   <= 1'b0;
            r_pend_last_p1 <= 1'b0;
            r_last_mem     <= 2'b00;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_addr   <= i_base_addr;
                r_count  <= i_word_count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_ONE;
                r_issued <= r_issued + CNT_ONE;
            end
            // Read stage: bram data for the read issued last cycle arrives now.
            r_pending_p1   <= w_issue;
            r_pend_last_p1 <= w_issue && (r_issued == (r_count - CNT_ONE));
            if (r_pending_p1) begin
                r_mem[r_wr_ptr]      <= i_ram_data;
                r_last_mem[r_wr_ptr] <= r_pend_last_p1;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_pending_p1} - {1'b0, w_pop};
        end
    end

    assign o_busy     = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);
    assign o_ram_addr = r_addr;
    assign o_valid    = (r_fifo_cnt != 2'd0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_last     = o_valid && r_last_mem[r_rd_ptr];

endmodule
